// File: rtl/fpm_seq_pkg.sv
// fpm_seq_pkg: shared state encoding, constants and width helper for fpm_seq
package fpm_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MUL_RST, MUL_WAIT, WRITE, DONE} state_t;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int TIMEOUT_DEF = 255;
  function automatic int aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fpm_seq_ram.sv
// fpm_seq_ram: result storage, sync write, comb read, async active-low clear
module fpm_seq_ram import fpm_seq_pkg::*; #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [aw(N)-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [aw(N)-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [N];
  // store one product per WRITE; whole array clears on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = int'(raddr) < N ? mem[raddr] : '0;
endmodule

// File: rtl/fpm_seq.sv
// fpm_seq: batch FP multiply sequencer (ROM -> fp_mult -> result RAM); FPM_SEQ_TIMEOUT_EN adds mul_done timeout
module fpm_seq import fpm_seq_pkg::*; #(
  parameter int N_PAIRS = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [aw(2*N_PAIRS)-1:0] rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        mul_a,
  output logic [DATA_W-1:0]        mul_b,
  output logic                     mul_rst,
  output logic                     mul_en,
  input  logic                     mul_done,
  input  logic [DATA_W-1:0]        mul_z,
  input  logic [aw(N_PAIRS)-1:0]   res_addr,
  output logic [DATA_W-1:0]        res_data
);
  localparam int AW  = aw(N_PAIRS);
  localparam int RAW = aw(2*N_PAIRS);
  state_t state, nxt;
  logic [AW-1:0] idx;
  logic last, accept, tmo_hit;
  logic [DATA_W-1:0] wdata;
  assign last   = int'(idx) == N_PAIRS - 1;
  assign accept = (state == IDLE || state == DONE) && start;
`ifdef FPM_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic tmo;
  assign tmo_hit = state == MUL_WAIT && !mul_done && int'(cnt) == TIMEOUT - 1;
  // wait counter, one-shot timeout marker for the following WRITE, sticky err
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      tmo <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= state == MUL_WAIT ? cnt + 1'b1 : '0;
      tmo <= tmo_hit;
      err <= accept ? 1'b0 : err | tmo_hit;
    end
  assign wdata = tmo ? DATA_W'(FP_QNAN) : mul_z;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
  assign wdata   = mul_z;
`endif
  // state, pair index and registered multiplier operands
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      state <= nxt;
      idx   <= accept ? '0 : state == WRITE && !last ? idx + 1'b1 : idx;
      if (state == LOAD_A) mul_a <= rom_data;
      if (state == LOAD_B) mul_b <= rom_data;
    end
  // next-state: linear walk per pair, loop back until the last pair is written
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: nxt = start ? LOAD_A : state;
      LOAD_A:     nxt = LOAD_B;
      LOAD_B:     nxt = MUL_RST;
      MUL_RST:    nxt = MUL_WAIT;
      MUL_WAIT:   nxt = mul_done || tmo_hit ? WRITE : MUL_WAIT;
      WRITE:      nxt = last ? DONE : LOAD_A;
      default:    nxt = IDLE;
    endcase
  end
  assign busy     = !(state == IDLE || state == DONE);
  assign done     = state == DONE;
  assign mul_en   = state == MUL_WAIT;
  assign mul_rst  = state == IDLE || state == MUL_RST || state == DONE;
  assign rom_addr = state == LOAD_A || state == LOAD_B ? RAW'({idx, state == LOAD_B}) : '0;
  fpm_seq_ram #(.N(N_PAIRS), .W(DATA_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (state == WRITE),
    .waddr (idx),
    .wdata (wdata),
    .raddr (res_addr),
    .rdata (res_data)
  );
endmodule

// File: tb/tb_fpm_seq.sv
// tb_fpm_seq: scoreboard bench for fpm_seq with a latency-programmable multiplier stub
module tb_fpm_seq;
  logic clk, rst, start, busy, done, err, mul_rst, mul_en, mul_done, hang;
  logic [1:0] rom_addr;
  logic [31:0] rom_data, mul_a, mul_b, mul_z, res_data;
  logic [0:0] res_addr;
  logic [31:0] rom [4];
  logic [31:0] exp_q [$];
  logic [31:0] model_ram [2];
  logic [7:0] scnt;
  int lat, tests, fails;

  fpm_seq #(.N_PAIRS(2), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .rom_addr(rom_addr), .rom_data(rom_data), .mul_a(mul_a), .mul_b(mul_b),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_done(mul_done), .mul_z(mul_z),
    .res_addr(res_addr), .res_data(res_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == 32'h3FC0_0000 && b == 32'hC000_0000) return 32'hC040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_data = rom[rom_addr];
  always_ff @(posedge clk)
    if (mul_rst) scnt <= '0;
    else if (mul_en) scnt <= scnt + 1'b1;
  assign mul_done = mul_en && !hang && int'(scnt) >= lat - 1;
  assign mul_z = fmul(mul_a, mul_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic push_batch;
    for (int k = 0; k < 2; k++) exp_q.push_back(fmul(rom[2*k], rom[2*k+1]));
  endtask

  task automatic run_to_done(input int c0, output int cyc, output int nrst);
    cyc = c0;
    nrst = 0;
    while (!done && cyc < 500) begin
      if (busy && mul_rst) nrst++;
      tick;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic load_rom_random;
    for (int k = 0; k < 4; k++) rom[k] = $urandom;
  endtask

  task automatic test_reset;
    rst = 0;
    start = 0;
    res_addr = 0;
    repeat (2) tick;
    tests += 7;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    if (mul_rst !== 1'b1) begin fails++; $display("FAIL reset_mul_rst got %b want 1", mul_rst); end
    if (mul_en !== 1'b0) begin fails++; $display("FAIL reset_mul_en got %b want 0", mul_en); end
    if ({mul_a, mul_b} !== 64'h0) begin fails++; $display("FAIL reset_mul_ab got %h %h want 0", mul_a, mul_b); end
    if (rom_addr !== 2'd0) begin fails++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      tests++;
      if (res_data !== 32'h0) begin fails++; $display("FAIL reset_res[%0d] got %h want 0", k, res_data); end
    end
    rst = 1;
    tick;
  endtask

  task automatic test_spec_batch;
    int cyc, nrst;
    rom[0] = 32'h4000_0000; rom[1] = 32'h4040_0000;
    rom[2] = 32'h3FC0_0000; rom[3] = 32'hC000_0000;
    lat = 1;
    exp_q.push_back(32'h40C0_0000);
    exp_q.push_back(32'hC040_0000);
    go;
    run_to_done(1, cyc, nrst);
    tests += 3;
    if (cyc != 11) begin fails++; $display("FAIL spec_done_cycle got %0d want 11", cyc); end
    if (nrst != 2) begin fails++; $display("FAIL spec_mul_rst_cycles got %0d want 2", nrst); end
    if (err !== 1'b0) begin fails++; $display("FAIL spec_err got %b want 0", err); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL spec_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
  endtask

  task automatic test_judge_during_batch;
    int cyc, nrst;
    load_rom_random;
    lat = 3;
    push_batch;
    go;
    repeat (6) tick;
    res_addr = 0;
    #1;
    tests++;
    if (res_data !== model_ram[0]) begin fails++; $display("FAIL judge_write_cycle res[0] got %h want %h", res_data, model_ram[0]); end
    tick;
    tests += 2;
    if (res_data !== exp_q[0]) begin fails++; $display("FAIL judge_after_write res[0] got %h want %h", res_data, exp_q[0]); end
    res_addr = 1;
    #1;
    if (res_data !== model_ram[1]) begin fails++; $display("FAIL judge_old res[1] got %h want %h", res_data, model_ram[1]); end
    run_to_done(8, cyc, nrst);
    tests++;
    if (cyc != 15) begin fails++; $display("FAIL judge_done_cycle got %0d want 15", cyc); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL judge_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, nrst;
    load_rom_random;
    lat = 2;
    push_batch;
    go;
    tick;
    start = 1;
    tick;
    start = 0;
    tick;
    start = 1;
    tick;
    start = 0;
    run_to_done(5, cyc, nrst);
    tests++;
    if (cyc != 13) begin fails++; $display("FAIL busy_start_done_cycle got %0d want 13", cyc); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL busy_start_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
    push_batch;
    go;
    tests += 2;
    if (done !== 1'b0) begin fails++; $display("FAIL rerun_done_drop got %b want 0", done); end
    if (busy !== 1'b1) begin fails++; $display("FAIL rerun_busy got %b want 1", busy); end
    run_to_done(1, cyc, nrst);
    tests++;
    if (cyc != 13) begin fails++; $display("FAIL rerun_done_cycle got %0d want 13", cyc); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL rerun_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
  endtask

  task automatic test_async_reset;
    int cyc, nrst;
    load_rom_random;
    lat = 4;
    push_batch;
    go;
    repeat (12) tick;
    tests++;
    if (!(busy === 1'b1 && mul_en === 1'b1)) begin fails++; $display("FAIL areset_pre busy/mul_en got %b%b want 11", busy, mul_en); end
    #1 rst = 0;
    #1;
    tests += 6;
    if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL areset_done got %b want 0", done); end
    if (mul_rst !== 1'b1) begin fails++; $display("FAIL areset_mul_rst got %b want 1", mul_rst); end
    if (mul_en !== 1'b0) begin fails++; $display("FAIL areset_mul_en got %b want 0", mul_en); end
    if ({mul_a, mul_b} !== 64'h0) begin fails++; $display("FAIL areset_mul_ab got %h %h want 0", mul_a, mul_b); end
    if (rom_addr !== 2'd0) begin fails++; $display("FAIL areset_rom_addr got %0d want 0", rom_addr); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = '0;
      tests++;
      if (res_data !== 32'h0) begin fails++; $display("FAIL areset_res[%0d] got %h want 0", k, res_data); end
    end
    exp_q.delete();
    #1 rst = 1;
    repeat (3) tick;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL areset_idle_busy got %b want 0", busy); end
    lat = 1;
    push_batch;
    go;
    run_to_done(1, cyc, nrst);
    tests++;
    if (cyc != 11) begin fails++; $display("FAIL areset_fresh_done_cycle got %0d want 11", cyc); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL areset_fresh_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
  endtask

`ifdef FPM_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int cyc, nrst, n;
    load_rom_random;
    lat = 2;
    hang = 1;
    exp_q.push_back(32'h7FC0_0000);
    exp_q.push_back(fmul(rom[2], rom[3]));
    go;
    cyc = 1;
    n = 0;
    while (cyc < 200) begin
      if (busy && mul_rst) n++;
      if (n == 2) break;
      tick;
      cyc++;
    end
    hang = 0;
    run_to_done(cyc, cyc, nrst);
    tests += 2;
    if (cyc != 19) begin fails++; $display("FAIL timeout_done_cycle got %0d want 19", cyc); end
    if (err !== 1'b1) begin fails++; $display("FAIL timeout_err got %b want 1", err); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL timeout_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
    push_batch;
    go;
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL timeout_err_clear got %b want 0", err); end
    run_to_done(1, cyc, nrst);
    tests += 2;
    if (cyc != 13) begin fails++; $display("FAIL timeout_rerun_cycle got %0d want 13", cyc); end
    if (err !== 1'b0) begin fails++; $display("FAIL timeout_rerun_err got %b want 0", err); end
    for (int k = 0; k < 2; k++) begin
      res_addr = k[0];
      #1;
      model_ram[k] = exp_q.pop_front();
      tests++;
      if (res_data !== model_ram[k]) begin fails++; $display("FAIL timeout_rerun_res[%0d] got %h want %h", k, res_data, model_ram[k]); end
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    hang = 0;
    lat = 1;
    for (int k = 0; k < 4; k++) rom[k] = '0;
    test_reset;
    test_spec_batch;
    test_judge_during_batch;
    test_back_to_back;
    test_async_reset;
`ifdef FPM_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
